// File: rtl/floor_indicator.sv
// ============================================================================
// Module   : floor_indicator
// Function : Elevator floor display with direction flags, settle-based arrival
//            pulse and a sticky out-of-range error flag.
//            Optional FLOOR_INDICATOR_SEG7_EN adds a registered 7-segment output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module floor_indicator #(
   parameter int FLOOR_W       = 4,
   parameter int NUM_FLOORS    = 8,
   parameter int SETTLE_CYCLES = 3,
   parameter int ARRIVE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOOR_W-1:0] floor,
   input  logic               floor_valid,
   input  logic               clr_err,
`ifdef FLOOR_INDICATOR_SEG7_EN
   output logic [6:0]         seg,
`endif
   output logic [FLOOR_W-1:0] display,
   output logic               dir_up,
   output logic               dir_down,
   output logic               arrived,
   output logic               err
);

   localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam int c_ARRIVE_W = $clog2(ARRIVE_CYCLES + 1);
   localparam logic [c_SETTLE_W-1:0] c_SETTLE_DONE = c_SETTLE_W'(SETTLE_CYCLES);
   localparam logic [c_ARRIVE_W-1:0] c_PULSE_LAST  = c_ARRIVE_W'(ARRIVE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MOVING  = 2'd1,
      S_ARRIVED = 2'd2
   } state_t;

   state_t                r_state, w_state_next;
   logic [FLOOR_W-1:0]    r_display, w_display_next;
   logic                  r_dir_up, w_dir_up_next;
   logic                  r_dir_down, w_dir_down_next;
   logic                  r_arrived, w_arrived_next;
   logic                  r_err, w_err_next;
   logic [c_SETTLE_W-1:0] r_settle, w_settle_next, w_settle_inc;
   logic [c_ARRIVE_W-1:0] r_pulse, w_pulse_next;

   logic w_in_range, w_accept, w_bad, w_up, w_down, w_change;

   always_comb begin
      w_in_range = (32'(floor) < NUM_FLOORS);
      w_accept   = floor_valid && w_in_range;
      w_bad      = floor_valid && !w_in_range;
      w_up       = w_accept && (floor > r_display);
      w_down     = w_accept && (floor < r_display);
      w_change   = w_up || w_down;
   end

   always_comb begin
      w_state_next    = r_state;
      w_display_next  = r_display;
      w_dir_up_next   = r_dir_up;
      w_dir_down_next = r_dir_down;
      w_arrived_next  = r_arrived;
      w_err_next      = r_err;
      w_settle_next   = r_settle;
      w_pulse_next    = r_pulse;
      w_settle_inc    = r_settle + 1'b1;

      // Setting the error takes priority over clearing it
      if (w_bad) begin
         w_err_next = 1'b1;
      end else if (clr_err) begin
         w_err_next = 1'b0;
      end

      if (w_change) begin
         w_display_next  = floor;
         w_dir_up_next   = w_up;
         w_dir_down_next = w_down;
      end

      // An out-of-range sample freezes the whole FSM for that cycle
      if (!w_bad) begin
         case (r_state)
            S_IDLE: begin
               if (w_change) begin
                  w_state_next  = S_MOVING;
                  w_settle_next = '0;
               end
            end
            S_MOVING: begin
               if (w_change) begin
                  w_settle_next = '0;
               end else begin
                  w_settle_next = w_settle_inc;
                  if (w_settle_inc == c_SETTLE_DONE) begin
                     w_state_next    = S_ARRIVED;
                     w_arrived_next  = 1'b1;
                     w_dir_up_next   = 1'b0;
                     w_dir_down_next = 1'b0;
                     w_pulse_next    = '0;
                  end
               end
            end
            S_ARRIVED: begin
               if (w_change) begin
                  w_state_next   = S_MOVING;
                  w_arrived_next = 1'b0;
                  w_settle_next  = '0;
               end else if (r_pulse == c_PULSE_LAST) begin
                  w_state_next   = S_IDLE;
                  w_arrived_next = 1'b0;
                  w_pulse_next   = '0;
               end else begin
                  w_pulse_next = r_pulse + 1'b1;
               end
            end
            default: begin
               w_state_next   = S_IDLE;
               w_arrived_next = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_display  <= '0;
         r_dir_up   <= 1'b0;
         r_dir_down <= 1'b0;
         r_arrived  <= 1'b0;
         r_err      <= 1'b0;
         r_settle   <= '0;
         r_pulse    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_display  <= w_display_next;
         r_dir_up   <= w_dir_up_next;
         r_dir_down <= w_dir_down_next;
         r_arrived  <= w_arrived_next;
         r_err      <= w_err_next;
         r_settle   <= w_settle_next;
         r_pulse    <= w_pulse_next;
      end
   end

`ifdef FLOOR_INDICATOR_SEG7_EN
   logic [3:0] w_digit;
   logic [6:0] w_seg_next;
   logic [6:0] r_seg;

   // Decoded from the next display value so seg and display update together
   always_comb begin
      w_digit = 4'(32'(w_display_next) % 32'd10);
      case (w_digit)
         4'd0:    w_seg_next = 7'b0111111;
         4'd1:    w_seg_next = 7'b0000110;
         4'd2:    w_seg_next = 7'b1011011;
         4'd3:    w_seg_next = 7'b1001111;
         4'd4:    w_seg_next = 7'b1100110;
         4'd5:    w_seg_next = 7'b1101101;
         4'd6:    w_seg_next = 7'b1111101;
         4'd7:    w_seg_next = 7'b0000111;
         4'd8:    w_seg_next = 7'b1111111;
         4'd9:    w_seg_next = 7'b1101111;
         default: w_seg_next = 7'b0111111;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg <= 7'b0111111;
      end else begin
         r_seg <= w_seg_next;
      end
   end

   assign seg = r_seg;
`endif

   assign display  = r_display;
   assign dir_up   = r_dir_up;
   assign dir_down = r_dir_down;
   assign arrived  = r_arrived;
   assign err      = r_err;

endmodule

`default_nettype wire

// File: doc/floor_indicator.md
FLOOR_INDICATOR -- requirements
Module: floor_indicator

Interface
REQ-001 SHALL have parameter FLOOR_W, default 4: floor code width in bits.
REQ-002 SHALL have parameter NUM_FLOORS, default 8: number of valid floors, codes 0..NUM_FLOORS-1; NUM_FLOORS <= 2**FLOOR_W.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 3 (>=1): number of consecutive stable cycles that declare arrival.
REQ-004 SHALL have parameter ARRIVE_CYCLES, default 2 (>=1): width of the arrived pulse, in cycles.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port floor, input, FLOOR_W: candidate floor code.
REQ-008 SHALL have port floor_valid, input, 1: floor is sampled only when this is high.
REQ-009 SHALL have port clr_err, input, 1: clears the err output.
REQ-010 SHALL have port display, output, FLOOR_W: registered current floor.
REQ-011 SHALL have port dir_up, output, 1: last accepted move was upward.
REQ-012 SHALL have port dir_down, output, 1: last accepted move was downward.
REQ-013 SHALL have port arrived, output, 1: arrival pulse.
REQ-014 SHALL have port err, output, 1: sticky flag for an out-of-range floor.

Function
REQ-015 A sample is accepted when floor_valid=1 and floor<NUM_FLOORS; display SHALL take the accepted value one cycle later (latency 1).
REQ-016 A sample with floor_valid=1 and floor>=NUM_FLOORS SHALL leave display, dir_up, dir_down and the FSM unchanged, and SHALL set err on the next edge.
REQ-017 err SHALL stay high until clr_err=1; if clr_err=1 in the same cycle as an invalid sample, set wins.
REQ-018 An accepted floor greater than display is a change: dir_up=1, dir_down=0, registered together with display.
REQ-019 An accepted floor less than display is a change: dir_up=0, dir_down=1.
REQ-020 An accepted floor equal to display is not a change: display and dir are unchanged.
REQ-021 dir_up and dir_down SHALL never both be 1.
REQ-022 The FSM SHALL have three states: IDLE, MOVING and ARRIVED, plus a settle counter of width $clog2(SETTLE_CYCLES+1).
REQ-023 IDLE: on a change, go to MOVING and clear the settle counter.
REQ-024 MOVING: on a change, clear the counter; on a cycle with no change, increment it; when it reaches SETTLE_CYCLES, go to ARRIVED.
REQ-025 Entry into ARRIVED SHALL clear dir_up and dir_down and SHALL assert arrived for exactly ARRIVE_CYCLES cycles, then return to IDLE.
REQ-026 A change while in ARRIVED SHALL immediately go to MOVING, drop arrived on the next edge and apply the new dir (change wins over the pulse).
REQ-027 Cycles with floor_valid=0 count as no-change cycles.

Reset
REQ-028 Reset SHALL asynchronously force display=0, dir_up=0, dir_down=0, arrived=0, err=0, the FSM to IDLE and the counters to 0, including during MOVING or ARRIVED.
REQ-029 The first rising edge after reset deassertion SHALL sample the inputs normally.

Configuration
REQ-030 With macro FLOOR_INDICATOR_SEG7_EN defined, SHALL add output seg[6:0] (active-high, bit order gfedcba).
- seg is a registered decode of (display mod 10), updated in the same cycle as display.
- seg resets to the pattern for '0' (7'b0111111).
REQ-031 Without FLOOR_INDICATOR_SEG7_EN, the seg port and its logic SHALL be absent, and all other behaviour is identical.

Verification (defaults: FLOOR_W=4, NUM_FLOORS=8, SETTLE_CYCLES=3, ARRIVE_CYCLES=2)
REQ-032 Reset, then floor=5 with floor_valid=1 for one cycle -> display=5 and dir_up=1 one cycle later; arrived high for 2 cycles starting at the 3rd edge after the change, with dir cleared on that same edge.
REQ-033 display=5, then floor=2 valid -> dir_down=1; floor=6 valid on the 2nd settle cycle -> dir_up=1, counter restarts, no arrived pulse until 3 further stable cycles.
REQ-034 floor=9 valid -> display held, err=1 on the next edge; clr_err pulse -> err=0; clr_err together with floor=12 valid -> err stays 1.
REQ-035 Reset asserted mid-ARRIVED -> arrived, display, dir and err all 0 immediately, without waiting for a clock edge.
REQ-036 floor_valid=0 while floor toggles -> display unchanged, settle count advances; with FLOOR_INDICATOR_SEG7_EN and display=7 -> seg=7'b0000111.
